// File: rtl/obi_mem_responder.sv
// obi_mem_responder
//   Memory-side responder for a req/gnt/rvalid core bus. Grants requests
//   when the response FIFO has room, applies writes with byte enables,
//   captures read data at the grant edge and returns responses in order.
//   Grant and response can each be withheld by the free stall inputs.
//
//   Optional build macro: OBI_RESP_ERR_EN
//     Adds err_o. Accesses whose offset from BASE_ADDR falls outside the
//     backing array are flagged instead of aliasing. Flagged writes leave
//     memory untouched, and flagged reads return 32'hDEAD_BEEF.
//   Without the macro, out-of-range offsets alias modulo MEM_WORDS*4 bytes.

module obi_mem_responder #(
   parameter int unsigned MEM_WORDS       = 256,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] BASE_ADDR       = 32'h1A00_0000,
   parameter logic [31:0] INIT_WORD       = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        rvalid_o,
   input  logic        gnt_stall_i,
   input  logic        rvalid_stall_i,
   output logic [2:0]  outstanding_o
`ifdef OBI_RESP_ERR_EN
   ,
   output logic        err_o
`endif
);

   localparam int unsigned AW        = $clog2(MEM_WORDS);
   localparam int unsigned PW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [2:0]  MAX_CNT   = 3'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUTSTANDING - 1);
   localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

   // Backing store and response FIFO
   logic [31:0]   mem_q       [MEM_WORDS];
   logic [31:0]   fifo_data_q [MAX_OUTSTANDING];
`ifdef OBI_RESP_ERR_EN
   logic          fifo_err_q  [MAX_OUTSTANDING];
`endif

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0]    count_q, count_d;

   // Address decode and handshake terms
   logic [31:0]   offset;
   logic [AW-1:0] index;
   logic          addr_err;
   logic          push;
   logic          pop;
   logic          empty;
   logic          mem_write;
   logic [31:0]   push_data;
   logic [31:0]   rd_word;

   // Byte-offset bits and (in the aliasing build) high offset bits carry no meaning
   logic          unused_addr_bits;
   assign unused_addr_bits = ^{offset[1:0], offset[31:AW+2]};

   // Decode the request address relative to the base of the array
   always_comb begin
      offset = addr_i - BASE_ADDR;
      index  = offset[AW+1:2];
`ifdef OBI_RESP_ERR_EN
      addr_err = (offset[31:AW+2] != '0);
`else
      addr_err = 1'b0;
`endif
   end

   // Grant, response and FIFO push/pop qualification
   always_comb begin
      empty    = (count_q == '0);
      gnt_o    = req_i & ~gnt_stall_i & (count_q < MAX_CNT) & ~reset;
      rvalid_o = ~empty & ~rvalid_stall_i & ~reset;
      push     = gnt_o;
      pop      = rvalid_o;
      mem_write = push & we_i & ~addr_err;
   end

   // Entry data captured at the grant edge; the read sees memory before any write
   always_comb begin
      rd_word = mem_q[index];
      if (we_i) begin
         push_data = '0;
      end else if (addr_err) begin
         push_data = ERR_DATA;
      end else begin
         push_data = rd_word;
      end
   end

   // Response outputs come straight from the FIFO head, zeroed when not valid
   always_comb begin
      rdata_o       = rvalid_o ? fifo_data_q[rd_ptr_q] : '0;
      outstanding_o = reset ? '0 : count_q;
`ifdef OBI_RESP_ERR_EN
      err_o         = rvalid_o & fifo_err_q[rd_ptr_q];
`endif
   end

   // Next-state for circular pointers and occupancy count
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage: write the pushed entry at the tail slot
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_data_q[i] <= '0;
`ifdef OBI_RESP_ERR_EN
            fifo_err_q[i]  <= 1'b0;
`endif
         end
      end else if (push) begin
         fifo_data_q[wr_ptr_q] <= push_data;
`ifdef OBI_RESP_ERR_EN
         fifo_err_q[wr_ptr_q]  <= addr_err;
`endif
      end
   end

   // Backing memory: reset fill, then byte-enabled writes on granted stores
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < MEM_WORDS; i++) begin
            mem_q[i] <= INIT_WORD;
         end
      end else if (mem_write) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (be_i[k]) begin
               mem_q[index][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb_obi_mem_responder
//   Directed steps followed by a randomized phase. Each cycle the DUT's
//   combinational outputs are compared against a queue-based reference of
//   the responder, and the reference is advanced for the coming edge.
//   Build with OBI_RESP_ERR_EN defined to exercise err_o.

module tb_obi_mem_responder;

   localparam int unsigned MEM_WORDS = 256;
   localparam int unsigned MAXO      = 2;
   localparam logic [31:0] BASE      = 32'h1A00_0000;
   localparam logic [31:0] INIT      = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_i = 1'b0;
   logic        gnt_o;
   logic [31:0] addr_i = '0;
   logic        we_i = 1'b0;
   logic [3:0]  be_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic        rvalid_o;
   logic        gnt_stall_i = 1'b0;
   logic        rvalid_stall_i = 1'b0;
   logic [2:0]  outstanding_o;
`ifdef OBI_RESP_ERR_EN
   logic        err_o;
`endif

   always #5 clock = ~clock;

   obi_mem_responder #(
      .MEM_WORDS(MEM_WORDS),
      .MAX_OUTSTANDING(MAXO),
      .BASE_ADDR(BASE),
      .INIT_WORD(INIT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .req_i(req_i),
      .gnt_o(gnt_o),
      .addr_i(addr_i),
      .we_i(we_i),
      .be_i(be_i),
      .wdata_i(wdata_i),
      .rdata_o(rdata_o),
      .rvalid_o(rvalid_o),
      .gnt_stall_i(gnt_stall_i),
      .rvalid_stall_i(rvalid_stall_i),
      .outstanding_o(outstanding_o)
`ifdef OBI_RESP_ERR_EN
      ,
      .err_o(err_o)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference: word array plus a queue of pending responses
   typedef struct {
      logic [31:0] data;
      logic        err;
   } resp_t;

   logic [31:0] model_mem [MEM_WORDS];
   resp_t       pend [$];

   // Observed values from the most recent step, for directed checks
   logic        obs_gnt;
   logic        obs_rvalid;
   logic [31:0] obs_rdata;
   logic [2:0]  obs_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic rq, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic gs, input logic rs);
      req_i          = rq;
      we_i           = we;
      be_i           = be;
      addr_i         = a;
      wdata_i        = wd;
      gnt_stall_i    = gs;
      rvalid_stall_i = rs;
   endtask

   // One clock: compare outputs mid-cycle, advance the reference, cross the edge
   task automatic step();
      logic        e_gnt;
      logic        e_rv;
      logic [31:0] e_rd;
      logic [31:0] off;
      int unsigned idx;
      resp_t       r;
      @(negedge clock);
      e_gnt = req_i && !gnt_stall_i && (pend.size() < MAXO) && !reset;
      e_rv  = (pend.size() > 0) && !rvalid_stall_i && !reset;
      e_rd  = e_rv ? pend[0].data : 32'h0;
      obs_gnt    = gnt_o;
      obs_rvalid = rvalid_o;
      obs_rdata  = rdata_o;
      obs_out    = outstanding_o;
      check("gnt", {31'b0, gnt_o}, {31'b0, e_gnt});
      check("rvalid", {31'b0, rvalid_o}, {31'b0, e_rv});
      check("rdata", rdata_o, e_rd);
      check("outstanding", {29'b0, outstanding_o}, reset ? 32'd0 : 32'(pend.size()));
`ifdef OBI_RESP_ERR_EN
      check("err", {31'b0, err_o}, {31'b0, (e_rv && pend[0].err)});
`endif
      if (reset) begin
         pend.delete();
         for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = INIT;
      end else begin
         if (e_rv) r = pend.pop_front();
         if (e_gnt) begin
            off = addr_i - BASE;
            idx = (off / 4) % MEM_WORDS;
`ifdef OBI_RESP_ERR_EN
            r.err = (off >= MEM_WORDS * 4);
`else
            r.err = 1'b0;
`endif
            if (we_i) begin
               r.data = 32'h0;
               if (!r.err)
                  for (int k = 0; k < 4; k++)
                     if (be_i[k]) model_mem[idx][8*k +: 8] = wdata_i[8*k +: 8];
            end else begin
               r.data = r.err ? 32'hDEAD_BEEF : model_mem[idx];
            end
            pend.push_back(r);
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset, with a request present to confirm it is ignored
      reset = 1'b1;
      set_in(1'b0, 1'b0, 4'h0, BASE, '0, 1'b0, 1'b0);
      step();
      set_in(1'b1, 1'b0, 4'h0, BASE, '0, 1'b0, 1'b0);
      step();
      check("rst_gnt", {31'b0, obs_gnt}, 32'd0);
      check("rst_out", {29'b0, obs_out}, 32'd0);
      reset = 1'b0;

      // Read of word 0 answers INIT one cycle after the grant
      set_in(1'b1, 1'b0, 4'hF, BASE, '0, 1'b0, 1'b0);
      step();
      check("t1_gnt", {31'b0, obs_gnt}, 32'd1);
      set_in(1'b0, 1'b0, 4'h0, BASE, '0, 1'b0, 1'b0);
      step();
      check("t1_rvalid", {31'b0, obs_rvalid}, 32'd1);
      check("t1_rdata", obs_rdata, 32'h0000_0013);

      // Partial write then read back the merged word
      set_in(1'b1, 1'b1, 4'b0011, BASE + 32'h10, 32'hAABB_CCDD, 1'b0, 1'b0);
      step();
      set_in(1'b1, 1'b0, 4'hF, BASE + 32'h10, '0, 1'b0, 1'b0);
      step();
      check("t2_wresp_rdata", obs_rdata, 32'h0);
      set_in(1'b0, 1'b0, 4'h0, BASE, '0, 1'b0, 1'b0);
      step();
      check("t2_rdata", obs_rdata, 32'h0000_CCDD);

      // Fill the FIFO under response stall, then drain
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b0, 4'hF, BASE + 32'h10 * (i + 1), '0, 1'b0, 1'b1);
         step();
      end
      check("t3_full_out", {29'b0, obs_out}, 32'd2);
      check("t3_full_gnt", {31'b0, obs_gnt}, 32'd0);
      set_in(1'b1, 1'b0, 4'hF, BASE + 32'h80, '0, 1'b0, 1'b0);
      step();
      check("t3_pop1_gnt", {31'b0, obs_gnt}, 32'd0);
      check("t3_pop1_rv", {31'b0, obs_rvalid}, 32'd1);
      check("t3_pop1_rd", obs_rdata, 32'h0000_CCDD);
      step();
      check("t3_regrant", {31'b0, obs_gnt}, 32'd1);
      check("t3_pop2_rv", {31'b0, obs_rvalid}, 32'd1);
      set_in(1'b0, 1'b0, 4'h0, BASE, '0, 1'b0, 1'b0);
      step();
      step();

      // Grant stall holds off everything for five cycles
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b0, 4'hF, BASE + 32'h4, '0, 1'b1, 1'b0);
         step();
         check("t4_gnt", {31'b0, obs_gnt}, 32'd0);
         check("t4_rv", {31'b0, obs_rvalid}, 32'd0);
      end
      set_in(1'b1, 1'b0, 4'hF, BASE + 32'h4, '0, 1'b0, 1'b0);
      step();
      check("t4_gnt_after", {31'b0, obs_gnt}, 32'd1);
      set_in(1'b0, 1'b0, 4'h0, BASE, '0, 1'b0, 1'b0);
      step();

      // Reset with two transactions pending drops them and restores memory
      set_in(1'b1, 1'b0, 4'hF, BASE + 32'h10, '0, 1'b0, 1'b1);
      step();
      step();
      set_in(1'b0, 1'b0, 4'h0, BASE, '0, 1'b0, 1'b0);
      reset = 1'b1;
      step();
      check("t5_rst_rv", {31'b0, obs_rvalid}, 32'd0);
      reset = 1'b0;
      step();
      check("t5_post_rv", {31'b0, obs_rvalid}, 32'd0);
      check("t5_post_out", {29'b0, obs_out}, 32'd0);
      set_in(1'b1, 1'b0, 4'hF, BASE + 32'h10, '0, 1'b0, 1'b0);
      step();
      set_in(1'b0, 1'b0, 4'h0, BASE, '0, 1'b0, 1'b0);
      step();
      check("t5_mem_init", obs_rdata, 32'h0000_0013);

      // Word 0 gets a distinct value, then the 0x400 alias is read
      set_in(1'b1, 1'b1, 4'hF, BASE, 32'h1234_5678, 1'b0, 1'b0);
      step();
      set_in(1'b1, 1'b0, 4'hF, BASE + 32'h400, '0, 1'b0, 1'b0);
      step();
      set_in(1'b0, 1'b0, 4'h0, BASE, '0, 1'b0, 1'b0);
      step();
`ifdef OBI_RESP_ERR_EN
      check("t6_err_rdata", obs_rdata, 32'hDEAD_BEEF);
`else
      check("t6_alias_rdata", obs_rdata, 32'h1234_5678);
`endif

      // Randomized traffic across the array and its alias window
      for (int i = 0; i < 600; i++) begin
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                BASE + $urandom_range(0, 32'h7FF), $urandom,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;
      set_in(1'b0, 1'b0, 4'h0, BASE, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step();
      check("drain_out", {29'b0, obs_out}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
